// File: rtl/nes_bus_pkg.sv
// rtl/nes_bus_pkg.sv - shared NES bus types and register addresses for the OAM DMA block.
package nes_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } dma_state_t;

  localparam logic [15:0] NES_OAM_DMA_ADDR = 16'h4014;
  localparam logic [15:0] NES_OAMDATA_ADDR = 16'h2004;

endpackage

// File: rtl/cpu_bus_mux.sv
// rtl/cpu_bus_mux.sv - selects the system bus master: CPU pass-through or DMA engine.
module cpu_bus_mux (
  input  logic        dma_sel_i,
  input  logic [15:0] cpu_a_i,
  input  logic [7:0]  cpu_d_i,
  input  logic        cpu_rd_i,
  input  logic        cpu_wr_i,
  input  logic [15:0] dma_a_i,
  input  logic [7:0]  dma_d_i,
  input  logic        dma_rd_i,
  input  logic        dma_wr_i,
  output logic [15:0] bus_a_o,
  output logic [7:0]  bus_d_o,
  output logic        bus_rd_o,
  output logic        bus_wr_o
);

  assign bus_a_o  = dma_sel_i ? dma_a_i  : cpu_a_i;
  assign bus_d_o  = dma_sel_i ? dma_d_i  : cpu_d_i;
  assign bus_rd_o = dma_sel_i ? dma_rd_i : cpu_rd_i;
  assign bus_wr_o = dma_sel_i ? dma_wr_i : cpu_wr_i;

endmodule

// File: rtl/oam_dma_ctrl.sv
// rtl/oam_dma_ctrl.sv - NES sprite OAM DMA controller; OAM_DMA_ALIGN_EN enables the get/put ALIGN cycle.
module oam_dma_ctrl
  import nes_bus_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = NES_OAM_DMA_ADDR,
  parameter logic [15:0] OAM_DATA_ADDR = NES_OAMDATA_ADDR
) (
  input  logic        clk_clk_i,
  input  logic        rst_rst_n_i,
  input  logic [15:0] cpu_a_i,
  input  logic [7:0]  cpu_d_i,
  input  logic        cpu_rd_i,
  input  logic        cpu_wr_i,
  output logic        rdy_o,
  output logic [15:0] bus_a_o,
  output logic [7:0]  bus_d_o,
  output logic        bus_rd_o,
  output logic        bus_wr_o,
  input  logic [7:0]  bus_d_i,
  output logic        dma_busy_o
);

  dma_state_t  state_q, state_d;
  logic        put_q;
  logic [7:0]  page_q, page_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  data_q, data_d;

  logic        dma_sel;
  logic [15:0] dma_a;
  logic [7:0]  dma_d;
  logic        dma_rd;
  logic        dma_wr;

  always_ff @(posedge clk_clk_i or negedge rst_rst_n_i) begin
    if (!rst_rst_n_i) begin
      state_q <= IDLE;
      put_q   <= 1'b0;
      page_q  <= 8'h00;
      idx_q   <= 8'h00;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      put_q   <= ~put_q;
      page_q  <= page_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    data_d  = data_q;
    dma_sel = 1'b0;
    dma_a   = {page_q, idx_q};
    dma_d   = data_q;
    dma_rd  = 1'b0;
    dma_wr  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cpu_wr_i && (cpu_a_i == DMA_REG_ADDR)) begin
          page_d  = cpu_d_i;
          idx_d   = 8'h00;
          state_d = HALT;
        end
      end
      HALT: begin
        // A 6502 write cycle cannot be stalled, so only a read cycle counts as the halt.
        if (!cpu_wr_i) begin
`ifdef OAM_DMA_ALIGN_EN
          state_d = put_q ? READ : ALIGN;
`else
          state_d = READ;
`endif
        end
      end
      ALIGN: begin
        dma_sel = 1'b1;
        state_d = READ;
      end
      READ: begin
        dma_sel = 1'b1;
        dma_rd  = 1'b1;
        data_d  = bus_d_i;
        state_d = WRITE;
      end
      WRITE: begin
        dma_sel = 1'b1;
        dma_a   = OAM_DATA_ADDR;
        dma_wr  = 1'b1;
        idx_d   = idx_q + 8'd1;
        state_d = (idx_q == 8'hFF) ? IDLE : READ;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rdy_o      = (state_q == IDLE);
  assign dma_busy_o = (state_q != IDLE);

  cpu_bus_mux u_bus_mux (
    .dma_sel_i (dma_sel),
    .cpu_a_i   (cpu_a_i),
    .cpu_d_i   (cpu_d_i),
    .cpu_rd_i  (cpu_rd_i),
    .cpu_wr_i  (cpu_wr_i),
    .dma_a_i   (dma_a),
    .dma_d_i   (dma_d),
    .dma_rd_i  (dma_rd),
    .dma_wr_i  (dma_wr),
    .bus_a_o   (bus_a_o),
    .bus_d_o   (bus_d_o),
    .bus_rd_o  (bus_rd_o),
    .bus_wr_o  (bus_wr_o)
  );

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb/tb_oam_dma_ctrl.sv - randomized self-checking bench for oam_dma_ctrl against a transfer-level model.
module tb_oam_dma_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_d;
  logic        cpu_rd;
  logic        cpu_wr;
  logic        rdy;
  logic [15:0] bus_a;
  logic [7:0]  bus_d;
  logic        bus_rd;
  logic        bus_wr;
  logic [7:0]  bus_din;
  logic        busy;

  logic [7:0]  mem [0:65535];
  logic        model_put;
  int          n_checks = 0;
  int          n_pass   = 0;

`ifdef OAM_DMA_ALIGN_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  oam_dma_ctrl dut (
    .clk_clk_i   (clk),
    .rst_rst_n_i (rst_n),
    .cpu_a_i     (cpu_a),
    .cpu_d_i     (cpu_d),
    .cpu_rd_i    (cpu_rd),
    .cpu_wr_i    (cpu_wr),
    .rdy_o       (rdy),
    .bus_a_o     (bus_a),
    .bus_d_o     (bus_d),
    .bus_rd_o    (bus_rd),
    .bus_wr_o    (bus_wr),
    .bus_d_i     (bus_din),
    .dma_busy_o  (busy)
  );

  always #5 clk = ~clk;

  assign bus_din = mem[bus_a];

  // Get/put parity: 0 right after reset, alternating every clock.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_put <= 1'b0;
    else        model_put <= ~model_put;
  end

  task automatic cpu_idle();
    cpu_wr = 1'b0;
    cpu_rd = 1'b1;
    cpu_a  = {1'b1, 15'($urandom)};
    cpu_d  = 8'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cpu_idle();
    #1;
    n_checks++;
    if (rdy !== 1'b1 || busy !== 1'b0)
      $display("FAIL reset_status rdy=%b busy=%b required rdy=1 busy=0", rdy, busy);
    else n_pass++;
    n_checks++;
    if (bus_a !== cpu_a || bus_d !== cpu_d || bus_rd !== cpu_rd || bus_wr !== cpu_wr)
      $display("FAIL reset_passthru bus=%h/%h/%b/%b required %h/%h/%b/%b",
               bus_a, bus_d, bus_rd, bus_wr, cpu_a, cpu_d, cpu_rd, cpu_wr);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_idle_passthrough();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cpu_a  = 16'($urandom);
      if (cpu_a == 16'h4014) cpu_a = 16'h4015;
      cpu_d  = 8'($urandom);
      cpu_rd = 1'($urandom);
      cpu_wr = ~cpu_rd;
      #1;
      n_checks++;
      if (bus_a !== cpu_a || bus_d !== cpu_d || bus_rd !== cpu_rd || bus_wr !== cpu_wr || rdy !== 1'b1)
        $display("FAIL idle_passthru[%0d] bus=%h/%h/%b/%b rdy=%b required %h/%h/%b/%b rdy=1",
                 i, bus_a, bus_d, bus_rd, bus_wr, rdy, cpu_a, cpu_d, cpu_rd, cpu_wr);
      else n_pass++;
    end
    @(negedge clk);
    cpu_idle();
  endtask

  task automatic test_dma(input logic [7:0] page, input bit want_put, input int n_hwr, input bit inject);
    int          low, quiet, exp_len, bad_rd, bad_wr, bad_busy, n_rd, n_wr;
    bit          hwr_ok;
    logic [15:0] dummy_a;
    cpu_idle();
    @(negedge clk);
    if (model_put !== want_put) @(negedge clk);
    cpu_rd = 1'b0;
    cpu_wr = 1'b1;
    cpu_a  = 16'h4014;
    cpu_d  = page;
    hwr_ok = 1'b1;
    for (int k = 0; k < n_hwr; k++) begin
      @(negedge clk);
      cpu_wr = 1'b1;
      cpu_a  = (k == 0) ? 16'h4014 : 16'($urandom);
      cpu_d  = (k == 0) ? ~page : 8'($urandom);
      #1;
      if (bus_a !== cpu_a || bus_d !== cpu_d || bus_wr !== 1'b1 || bus_rd !== 1'b0 ||
          rdy !== 1'b0 || busy !== 1'b1) hwr_ok = 1'b0;
    end
    if (n_hwr > 0) begin
      n_checks++;
      if (!hwr_ok) $display("FAIL halt_write_passthru page=%h observed=0 required=1", page);
      else n_pass++;
    end
    @(negedge clk);
    cpu_wr  = 1'b0;
    cpu_rd  = 1'b1;
    dummy_a = {1'b1, 15'($urandom)};
    cpu_a   = dummy_a;
    exp_len = 513 + ((ALIGN_EN && model_put == 1'b0) ? 1 : 0);
    #1;
    n_checks++;
    if (bus_a !== dummy_a || bus_rd !== 1'b1 || bus_wr !== 1'b0 || rdy !== 1'b0)
      $display("FAIL dummy_halt bus=%h rd=%b wr=%b rdy=%b required %h 1 0 0",
               bus_a, bus_rd, bus_wr, rdy, dummy_a);
    else n_pass++;
    low = 0; quiet = 0; bad_rd = 0; bad_wr = 0; bad_busy = 0; n_rd = 0; n_wr = 0;
    for (int c = 0; c < 700; c++) begin
      if (busy !== ~rdy) bad_busy++;
      if (rdy === 1'b1) break;
      low++;
      if (low > 1) begin
        if (bus_rd === 1'b1) begin
          if (bus_a !== {page, 8'(n_rd)}) bad_rd++;
          n_rd++;
        end
        if (bus_wr === 1'b1) begin
          if (bus_a !== 16'h2004 || bus_d !== mem[{page, 8'(n_wr)}]) bad_wr++;
          n_wr++;
        end
        if (bus_rd !== 1'b1 && bus_wr !== 1'b1) quiet++;
      end
      @(negedge clk);
      cpu_wr = (inject && low == 50);
      cpu_a  = (inject && low == 50) ? 16'h4014 : dummy_a;
      cpu_d  = page ^ 8'h55;
      #1;
    end
    cpu_idle();
    n_checks++;
    if (low !== exp_len) $display("FAIL halt_length page=%h observed=%0d required=%0d", page, low, exp_len);
    else n_pass++;
    n_checks++;
    if (n_rd !== 256 || bad_rd !== 0)
      $display("FAIL read_seq page=%h reads=%0d bad=%0d required 256 reads 0 bad", page, n_rd, bad_rd);
    else n_pass++;
    n_checks++;
    if (n_wr !== 256 || bad_wr !== 0)
      $display("FAIL oam_writes page=%h writes=%0d bad=%0d required 256 writes 0 bad", page, n_wr, bad_wr);
    else n_pass++;
    n_checks++;
    if (quiet !== exp_len - 513)
      $display("FAIL align_idle page=%h observed=%0d required=%0d", page, quiet, exp_len - 513);
    else n_pass++;
    n_checks++;
    if (bad_busy !== 0) $display("FAIL busy_vs_rdy observed=%0d required=0", bad_busy);
    else n_pass++;
  endtask

  task automatic test_reset_abort(input logic [7:0] page);
    int n_wr, late_wr, bad_rdy;
    cpu_idle();
    @(negedge clk);
    cpu_rd = 1'b0;
    cpu_wr = 1'b1;
    cpu_a  = 16'h4014;
    cpu_d  = page;
    @(negedge clk);
    cpu_idle();
    n_wr = 0;
    for (int c = 0; c < 400 && n_wr < 100; c++) begin
      #1;
      if (bus_wr === 1'b1 && bus_a === 16'h2004) n_wr++;
      if (n_wr < 100) @(negedge clk);
    end
    n_checks++;
    if (n_wr !== 100) $display("FAIL reach_100_writes observed=%0d required=100", n_wr);
    else n_pass++;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (rdy !== 1'b1 || busy !== 1'b0 || bus_a !== cpu_a || bus_rd !== cpu_rd || bus_wr !== cpu_wr)
      $display("FAIL abort_state rdy=%b busy=%b bus_a=%h required rdy=1 busy=0 bus_a=%h",
               rdy, busy, bus_a, cpu_a);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    late_wr = 0; bad_rdy = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (bus_wr === 1'b1 && bus_a === 16'h2004) late_wr++;
      if (rdy !== 1'b1) bad_rdy++;
    end
    n_checks++;
    if (late_wr !== 0 || bad_rdy !== 0)
      $display("FAIL post_abort oam_writes=%0d rdy_low=%0d required 0 0", late_wr, bad_rdy);
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    test_reset();
    test_idle_passthrough();
    test_dma(8'h02, 1'b0, 0, 1'b0);
    test_dma(8'h02, 1'b1, 0, 1'b0);
    test_dma(8'($urandom), 1'($urandom), 2, 1'b0);
    test_dma(8'($urandom), 1'($urandom), 0, 1'b1);
    for (int r = 0; r < 3; r++)
      test_dma(8'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    test_reset_abort(8'($urandom));
    test_dma(8'($urandom), 1'($urandom), 1, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
